// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory responder.
package mem_pkg;
    localparam int DEPTH_DEFAULT = 512;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } state_e;
endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM, DEPTH x 32, registered read port.
module mem_array #(
    parameter int DEPTH = 512
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic                     clr_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Output register resets and can be cleared; array contents never do.
    always_ff @(posedge clock_i) begin
        if (reset_i || clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - CPU memory responder with fixed wait states and done pulse.
// Optional address fault reporting: MEM_ADDR_CHECK_EN.
module memory_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q;
    logic [31:0]      wdata_q;
    logic             wr_q;
    logic             fault_q;

    logic             req;
    logic             idle;
    logic             fault_in;
    logic             go_resp;
    logic             cm_wr;
    logic             cm_fault;
    logic [AW-1:0]    cm_addr;
    logic [31:0]      cm_data;

    assign req  = Read | Write;
    assign idle = (state_q == IDLE);

`ifdef MEM_ADDR_CHECK_EN
    assign fault_in = (address >= 32'(DEPTH));
    assign err      = done & fault_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[31:AW];
    assign fault_in       = 1'b0;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end
            end
            RESP:    state_d = req ? HOLD : IDLE;
            HOLD:    state_d = req ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (idle && req) begin
                addr_q  <= address[AW-1:0];
                wdata_q <= wdata;
                wr_q    <= Write;
                fault_q <= fault_in;
            end
        end
    end

    // With no wait states the commit happens on the accepting edge itself,
    // so the live request is used instead of the latched copy.
    assign cm_addr  = idle ? address[AW-1:0] : addr_q;
    assign cm_data  = idle ? wdata : wdata_q;
    assign cm_wr    = idle ? Write : wr_q;
    assign cm_fault = idle ? fault_in : fault_q;

    mem_array #(.DEPTH(DEPTH)) u_mem (
        .clock_i (clock),
        .reset_i (reset),
        .we_i    (go_resp & cm_wr & ~cm_fault & ~reset),
        .re_i    (go_resp & ~cm_wr & ~cm_fault & ~reset),
        .clr_i   (go_resp & ~cm_wr & cm_fault),
        .addr_i  (cm_addr),
        .wdata_i (cm_data),
        .rdata_o (rdata)
    );

    assign done = (state_q == RESP);
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512, number of 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 2, extra cycles between acceptance and completion (legal range 0..15).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Read  input  1  read request level from CPU, held until done.
REQ-006 SHALL have port Write  input  1  write request level from CPU, held until done.
REQ-007 SHALL have port address  input  32  word address (driven from MAR).
REQ-008 SHALL have port wdata  input  32  write data (driven from MDR).
REQ-009 SHALL have port rdata  output  32  read data returned to MDR.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  address-fault flag, valid with done.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP, HOLD.
REQ-013 In IDLE, Read or Write high SHALL accept the request and latch address, wdata and operation type on that edge.
REQ-014 Read and Write both high SHALL be accepted as a write.
REQ-015 After acceptance, the FSM SHALL go to WAIT with the counter loaded to WAIT_STATES; if WAIT_STATES=0, it SHALL go directly to RESP.
REQ-016 WAIT SHALL decrement the counter each cycle and go to RESP after the cycle in which the counter reaches 1.
REQ-017 done SHALL be high for exactly one cycle, in RESP, WAIT_STATES+1 cycles after the accepting edge.
REQ-018 A write SHALL commit to the array on the edge entering RESP, using the latched address and data.
REQ-019 A read SHALL update rdata on the edge entering RESP; rdata SHALL hold its value until the next read completes.
REQ-020 Writes SHALL NOT modify rdata.
REQ-021 RESP SHALL go to HOLD, or to IDLE if Read and Write are both low.
REQ-022 HOLD SHALL stay until Read and Write are both low, then go to IDLE; a level held high SHALL NOT be re-accepted.
REQ-023 Changes on address, wdata, Read or Write after acceptance SHALL be ignored until IDLE.

Reset
REQ-024 reset SHALL force IDLE, clear the counter, and set rdata=0, done=0, err=0 on the next edge, overriding all other activity.
REQ-025 reset in WAIT SHALL abort the access: no write commit and no done pulse.
REQ-026 reset SHALL NOT clear the memory array contents.

Configuration
REQ-027 With MEM_ADDR_CHECK_EN defined, address >= DEPTH at acceptance SHALL complete with normal latency, done=1 and err=1, with no write and rdata forced to 0.
REQ-028 Without MEM_ADDR_CHECK_EN, err SHALL be tied to 0 and the address SHALL be truncated to its low log2(DEPTH) bits (wrap-around).

Structure
REQ-029 Package mem_pkg SHALL hold the FSM state typedef, the DEPTH default, and the counter width constant.
REQ-030 The storage SHALL be a sub-module mem_array: a single-port synchronous RAM of DEPTH x 32 bits, with write enable and registered read.

Verification
REQ-031 Reset, then Write of address=5, wdata=0xDEADBEEF held until done: done exactly 3 cycles after acceptance; then Read of address=5: rdata=0xDEADBEEF with done.
REQ-032 With WAIT_STATES=0, Read of address=5: done on the cycle after acceptance, then one-cycle pulse only while Read stays high for 4 more cycles.
REQ-033 Read and Write both high, address=7, wdata=0x12345678: treated as a write; a subsequent read of address 7 returns 0x12345678.
REQ-034 reset asserted one cycle after accepting Write of address=9, wdata=0x1: no done; a subsequent read of address 9 returns its prior value.
REQ-035 With the macro defined, Write to address=600: err=1, done=1, and word 88 unchanged. Without the macro, the same write lands in word 88 (600 mod 512) and err=0.
